// File: rtl/audio_i2s_sequencer.sv
// I2S frame controller: divides clk into BCLK/LRCLK, captures one stereo pair per
// 32-bit frame and shifts it out MSB-first as 16-bit two's complement words.
module audio_i2s_sequencer #(
    parameter int unsigned CLK_DIV = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mute,
    input  logic [8:0] left_in,
    input  logic [8:0] right_in,
    output logic       i2s_bclk,
    output logic       i2s_lrclk,
    output logic       i2s_sdata,
    output logic       sample_strobe
);
    localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic {
        LEFT_SLOT  = 1'b0,
        RIGHT_SLOT = 1'b1
    } slot_e;

    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic [4:0]       bit_cnt, bit_cnt_nxt;
    logic [4:0]       bit_pos, lead_pos;
    logic [31:0]      shift_reg, shift_reg_nxt;
    logic [15:0]      shadow_l, shadow_l_nxt;
    logic [15:0]      shadow_r, shadow_r_nxt;
    logic             bclk_nxt, lrclk_nxt, sdata_nxt, strobe_nxt;
    logic             div_wrap, bclk_fall, capture;
    slot_e            lead_slot;

    function automatic logic [15:0] to_twos(input logic [8:0] s);
        return {~s[8], s[7:0], 7'b0};
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt       <= '0;
            bit_cnt       <= '1;
            shift_reg     <= '0;
            shadow_l      <= '0;
            shadow_r      <= '0;
            i2s_bclk      <= 1'b0;
            i2s_lrclk     <= 1'b0;
            i2s_sdata     <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            div_cnt       <= div_cnt_nxt;
            bit_cnt       <= bit_cnt_nxt;
            shift_reg     <= shift_reg_nxt;
            shadow_l      <= shadow_l_nxt;
            shadow_r      <= shadow_r_nxt;
            i2s_bclk      <= bclk_nxt;
            i2s_lrclk     <= lrclk_nxt;
            i2s_sdata     <= sdata_nxt;
            sample_strobe <= strobe_nxt;
        end
    end

    // Next-state: divider, bit position, shifter and capture shadows
    always_comb begin
        div_wrap      = (div_cnt == DIV_LAST);
        bclk_fall     = div_wrap && i2s_bclk;
        bit_pos       = bit_cnt + 5'd1;
        capture       = bclk_fall && (bit_pos == 5'd31);
        div_cnt_nxt   = div_wrap ? '0 : div_cnt + DIV_W'(1);
        bit_cnt_nxt   = bclk_fall ? bit_pos : bit_cnt;
        shift_reg_nxt = shift_reg;
        shadow_l_nxt  = shadow_l;
        shadow_r_nxt  = shadow_r;

        if (bclk_fall) begin
            if (bit_pos == 5'd0)
                shift_reg_nxt = {shadow_l, shadow_r};
            else
                shift_reg_nxt = {shift_reg[30:0], 1'b0};
        end

        if (capture) begin
            shadow_l_nxt = mute ? '0 : to_twos(left_in);
            shadow_r_nxt = mute ? '0 : to_twos(right_in);
        end

        if (!en) begin
            div_cnt_nxt   = '0;
            bit_cnt_nxt   = '1;
            shift_reg_nxt = '0;
            shadow_l_nxt  = '0;
            shadow_r_nxt  = '0;
        end
    end

    // Outputs: LRCLK announces the slot of the bit after the one now being sent
    always_comb begin
        lead_pos   = bit_pos + 5'd1;
        lead_slot  = lead_pos[4] ? RIGHT_SLOT : LEFT_SLOT;
        bclk_nxt   = i2s_bclk ^ div_wrap;
        lrclk_nxt  = i2s_lrclk;
        sdata_nxt  = i2s_sdata;
        strobe_nxt = capture;

        if (bclk_fall) begin
            lrclk_nxt = (lead_slot == RIGHT_SLOT);
            sdata_nxt = shift_reg_nxt[31];
        end

        if (!en) begin
            bclk_nxt   = 1'b0;
            lrclk_nxt  = 1'b0;
            sdata_nxt  = 1'b0;
            strobe_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_i2s_sequencer.sv
// Scoreboard bench for audio_i2s_sequencer: stimulus queues expected frames, a
// monitor deframes the I2S stream by LRCLK and compares; a second monitor checks timing.
module tb_audio_i2s_sequencer;
    localparam int unsigned CLK_DIV = 2;

    localparam logic [8:0]  VL [6] = '{9'h1FF, 9'h100, 9'h1FF, 9'h000, 9'h155, 9'h001};
    localparam logic [8:0]  VR [6] = '{9'h000, 9'h100, 9'h1FF, 9'h1FF, 9'h0AA, 9'h0FF};
    localparam logic        VM [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [31:0] VE [6] = '{32'h7F80_8000, 32'h0000_0000, 32'h0000_0000,
                                       32'h8000_7F80, 32'h2A80_D500, 32'h8080_FF80};

    logic       clk = 1'b0;
    logic       rst, en, mute;
    logic [8:0] left_in, right_in;
    logic       i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned cyc     = 0;
    logic [31:0] exp_q[$];

    audio_i2s_sequencer #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mute         (mute),
        .left_in      (left_in),
        .right_in     (right_in),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .sample_strobe(sample_strobe)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, got, want);
    endtask

    function automatic logic [31:0] outs();
        return 32'({i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe});
    endfunction

    // Frame monitor: sample sdata on BCLK rises; a right word ends where LRCLK drops.
    initial begin
        logic        bclk_q, lr_q;
        logic [31:0] win;
        int unsigned nrise;
        bclk_q = 1'b0; lr_q = 1'b0; win = '0; nrise = 0;
        forever begin
            @(negedge clk);
            if (rst || !en) begin
                bclk_q = 1'b0; lr_q = 1'b0; nrise = 0;
            end else begin
                if (i2s_bclk && !bclk_q) begin
                    win = {win[30:0], i2s_sdata};
                    nrise++;
                    if (!i2s_lrclk && lr_q && nrise >= 32) begin
                        if (exp_q.size() == 0) begin
                            n_total++;
                            $display("FAIL frame: got %h, no expected frame queued", win);
                        end else begin
                            chk("frame", win, exp_q.pop_front());
                        end
                    end
                    lr_q = i2s_lrclk;
                end
                bclk_q = i2s_bclk;
            end
        end
    end

    // Timing monitor: strobe width/period/alignment and LRCLK high length.
    initial begin
        logic        strobe_q, bclk_t, lr_t, have_strobe;
        int unsigned lr_cnt, last_strobe;
        strobe_q = 1'b0; bclk_t = 1'b0; lr_t = 1'b0; have_strobe = 1'b0;
        lr_cnt = 0; last_strobe = 0;
        forever begin
            @(negedge clk);
            if (rst || !en) begin
                strobe_q = 1'b0; bclk_t = 1'b0; lr_t = 1'b0; have_strobe = 1'b0; lr_cnt = 0;
            end else begin
                if (sample_strobe) begin
                    chk("strobe_width", 32'(strobe_q), 32'd0);
                    chk("strobe_on_bclk_fall", 32'({bclk_t, i2s_bclk}), 32'b10);
                    if (have_strobe) chk("strobe_period", 32'(cyc - last_strobe), 32'd128);
                    last_strobe = cyc;
                    have_strobe = 1'b1;
                end
                if (i2s_lrclk && i2s_bclk && !bclk_t) lr_cnt++;
                if (lr_t && !i2s_lrclk) begin
                    chk("lrclk_high_bclks", 32'(lr_cnt), 32'd16);
                    lr_cnt = 0;
                end
                strobe_q = sample_strobe;
                bclk_t   = i2s_bclk;
                lr_t     = i2s_lrclk;
            end
        end
    end

    task automatic wait_strobe(output int unsigned n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!sample_strobe && n < 300);
        if (!sample_strobe) begin
            n_total++;
            $display("FAIL strobe_timeout: got no strobe in %0d clk, want one", n);
        end
    endtask

    // Called at the negedge where rst falls or en rises.
    task automatic restart_check(input string tag, input logic [31:0] first_cap);
        logic [3:0]  pat;
        int unsigned n;
        pat = '0;
        chk({tag, "_idle_outputs"}, outs(), 32'd0);
        exp_q.push_back('0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            pat = {pat[2:0], i2s_bclk};
        end
        chk({tag, "_bclk_clk1to4"}, 32'(pat), 32'b0110);
        wait_strobe(n);
        chk({tag, "_first_strobe_after_F"}, 32'(n), 32'd124);
        exp_q.push_back(first_cap);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        logic [3:0]  seen;
        rst = 1'b1; en = 1'b1;
        mute = VM[0]; left_in = VL[0]; right_in = VR[0];
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 32'd0);
        rst = 1'b0;
        restart_check("reset", VE[0]);

        for (int i = 1; i < 6; i++) begin
            // mid-frame noise, including mute, must not leak into any frame
            left_in = 9'($urandom); right_in = 9'($urandom); mute = 1'b1;
            repeat (40) @(negedge clk);
            mute = 1'b0; left_in = 9'($urandom); right_in = 9'($urandom);
            repeat (20) @(negedge clk);
            left_in = VL[i]; right_in = VR[i]; mute = VM[i];
            wait_strobe(n);
            exp_q.push_back(VE[i]);
        end
        mute = 1'b0;

        // abort during p=7 (F p=7 is 32 clk after the strobe)
        repeat (32) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("abort_next_clk", outs(), 32'd0);
        seen = '0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | outs()[3:0];
        end
        chk("abort_hold", 32'(seen), 32'd0);
        exp_q.delete();
        left_in = 9'h0AA; right_in = 9'h1FF;
        en = 1'b1;
        restart_check("enable", 32'hD500_7F80);

        // async reset at p=20: right word 7F80 bit 11 is a one
        repeat (84) @(negedge clk);
        chk("lrclk_sdata_at_p20", 32'({i2s_lrclk, i2s_sdata}), 32'b11);
        #2 rst = 1'b1;
        #1 chk("async_reset_immediate", outs(), 32'd0);
        exp_q.delete();
        left_in = 9'h100; right_in = 9'h1FF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        restart_check("async", 32'h0000_7F80);

        repeat (140) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
